// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I datapath: sequences fetch/decode/execute/
// memory/writeback and counts retired instructions.
module multicycle_main_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  output logic             pc_update,
  output logic             branch,
  output logic             reg_write,
  output logic             mem_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] retired_q;

  // State sequencing; the retire count bumps on every terminal state's return to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_R:         state_q <= S_EXECUTER;
            OP_I:         state_q <= S_EXECUTEI;
            OP_JAL:       state_q <= S_JAL;
            OP_BEQ:       state_q <= S_BEQ;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR:   state_q <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state_q <= S_MEMWB;
        S_EXECUTER: state_q <= S_ALUWB;
        S_EXECUTEI: state_q <= S_ALUWB;
        S_JAL:      state_q <= S_ALUWB;
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: begin
          state_q   <= S_FETCH;
          retired_q <= retired_q + CNT_W'(1);
        end
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; unlisted outputs and unreachable encodings stay 0.
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: state sequences, per-state controls,
// retire counting, async reset abort and 4-bit counter wrap.
module tb_multicycle_main_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [6:0]  op, op2;
  logic        pc_update, branch, reg_write, mem_write, ir_write, adr_src;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] retired;
  logic        pc_update2, branch2, reg_write2, mem_write2, ir_write2, adr_src2;
  logic [1:0]  result_src2, alu_src_a2, alu_src_b2, alu_op2;
  logic [3:0]  state2;
  logic [3:0]  retired2;
  logic [13:0] ctrl;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ret_exp = 32'd0;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op),
    .pc_update(pc_update), .branch(branch), .reg_write(reg_write), .mem_write(mem_write),
    .ir_write(ir_write), .adr_src(adr_src), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .retired(retired)
  );

  multicycle_main_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst2), .op(op2),
    .pc_update(pc_update2), .branch(branch2), .reg_write(reg_write2), .mem_write(mem_write2),
    .ir_write(ir_write2), .adr_src(adr_src2), .result_src(result_src2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .state(state2), .retired(retired2)
  );

  assign ctrl = {pc_update, branch, reg_write, mem_write, ir_write, adr_src,
                 result_src, alu_src_a, alu_src_b, alu_op};

  // Expected controls per state, packed as ctrl above.
  function automatic logic [13:0] exp_ctrl(input logic [3:0] s);
    case (s)
      4'd0:    return {6'b100010, 2'b10, 2'b00, 2'b10, 2'b00};
      4'd1:    return {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
      4'd2:    return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
      4'd3:    return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
      4'd4:    return {6'b001000, 2'b01, 2'b00, 2'b00, 2'b00};
      4'd5:    return {6'b000101, 2'b00, 2'b00, 2'b00, 2'b00};
      4'd6:    return {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
      4'd7:    return {6'b001000, 2'b00, 2'b00, 2'b00, 2'b00};
      4'd8:    return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10};
      4'd9:    return {6'b100000, 2'b00, 2'b01, 2'b10, 2'b00};
      4'd10:   return {6'b010000, 2'b00, 2'b10, 2'b00, 2'b01};
      default: return 14'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; op = OP_R; op2 = OP_R;
    #12;
    vectors++;
    if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
    vectors++;
    if (ctrl !== exp_ctrl(4'd0)) begin miscompares++; $display("FAIL reset_ctrl: got %b want %b", ctrl, exp_ctrl(4'd0)); end
    vectors++;
    if (retired !== 32'd0) begin miscompares++; $display("FAIL reset_retired: got %0d want 0", retired); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    op = OP_R;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (state !== seq[i]) begin miscompares++; $display("FAIL r_state[%0d]: got %0d want %0d", i, state, seq[i]); end
      vectors++;
      if (ctrl !== exp_ctrl(seq[i])) begin miscompares++; $display("FAIL r_ctrl[%0d]: got %b want %b", i, ctrl, exp_ctrl(seq[i])); end
      tick();
    end
    ret_exp++;
    vectors++;
    if (state !== 4'd0 || retired !== ret_exp) begin
      miscompares++; $display("FAIL r_end: state %0d retired %0d want 0/%0d", state, retired, ret_exp);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    op = OP_LW;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) op = OP_R;  // op must be ignored after MEMADR
      vectors++;
      if (state !== seq[i]) begin miscompares++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i]); end
      vectors++;
      if (ctrl !== exp_ctrl(seq[i])) begin miscompares++; $display("FAIL lw_ctrl[%0d]: got %b want %b", i, ctrl, exp_ctrl(seq[i])); end
      tick();
    end
    ret_exp++;
    vectors++;
    if (state !== 4'd0 || retired !== ret_exp) begin
      miscompares++; $display("FAIL lw_end: state %0d retired %0d want 0/%0d", state, retired, ret_exp);
    end
  endtask

  task automatic test_sw();
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    int mw_cycles = 0;
    int rw_cycles = 0;
    op = OP_SW;
    for (int i = 0; i < 4; i++) begin
      if (mem_write) mw_cycles++;
      if (reg_write) rw_cycles++;
      vectors++;
      if (state !== seq[i]) begin miscompares++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, seq[i]); end
      vectors++;
      if (ctrl !== exp_ctrl(seq[i])) begin miscompares++; $display("FAIL sw_ctrl[%0d]: got %b want %b", i, ctrl, exp_ctrl(seq[i])); end
      tick();
    end
    ret_exp++;
    vectors++;
    if (mw_cycles != 1 || rw_cycles != 0) begin
      miscompares++; $display("FAIL sw_strobes: mem_write %0d reg_write %0d cycles, want 1/0", mw_cycles, rw_cycles);
    end
    vectors++;
    if (state !== 4'd0 || retired !== ret_exp) begin
      miscompares++; $display("FAIL sw_end: state %0d retired %0d want 0/%0d", state, retired, ret_exp);
    end
  endtask

  task automatic test_beq_jal();
    logic [3:0] sb [3] = '{4'd0, 4'd1, 4'd10};
    logic [3:0] sj [4] = '{4'd0, 4'd1, 4'd9, 4'd7};
    op = OP_BEQ;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (state !== sb[i]) begin miscompares++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, state, sb[i]); end
      vectors++;
      if (ctrl !== exp_ctrl(sb[i])) begin miscompares++; $display("FAIL beq_ctrl[%0d]: got %b want %b", i, ctrl, exp_ctrl(sb[i])); end
      tick();
    end
    op = OP_JAL;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (state !== sj[i]) begin miscompares++; $display("FAIL jal_state[%0d]: got %0d want %0d", i, state, sj[i]); end
      vectors++;
      if (ctrl !== exp_ctrl(sj[i])) begin miscompares++; $display("FAIL jal_ctrl[%0d]: got %b want %b", i, ctrl, exp_ctrl(sj[i])); end
      tick();
    end
    ret_exp = ret_exp + 32'd2;
    vectors++;
    if (state !== 4'd0 || retired !== ret_exp) begin
      miscompares++; $display("FAIL beqjal_end: state %0d retired %0d want 0/%0d", state, retired, ret_exp);
    end
  endtask

  task automatic test_illegal();
    op = OP_BAD;
    tick();
    vectors++;
    if (state !== 4'd1) begin miscompares++; $display("FAIL ill_decode: got %0d want 1", state); end
    tick();
    vectors++;
    if (state !== 4'd0 || retired !== ret_exp) begin
      miscompares++; $display("FAIL ill_end: state %0d retired %0d want 0/%0d", state, retired, ret_exp);
    end
  endtask

  task automatic test_reset_abort();
    op = OP_LW;
    tick(); tick(); tick();
    vectors++;
    if (state !== 4'd3 || retired !== ret_exp) begin
      miscompares++; $display("FAIL abort_pre: state %0d retired %0d want 3/%0d", state, retired, ret_exp);
    end
    #2 rst = 1'b1;
    #1;
    ret_exp = 32'd0;
    vectors++;
    if (state !== 4'd0 || retired !== 32'd0) begin
      miscompares++; $display("FAIL abort_async: state %0d retired %0d want 0/0", state, retired);
    end
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (ctrl !== exp_ctrl(4'd0)) begin miscompares++; $display("FAIL abort_ctrl: got %b want %b", ctrl, exp_ctrl(4'd0)); end
  endtask

  task automatic test_wrap();
    op2 = OP_R;
    @(negedge clk);
    rst2 = 1'b0;
    repeat (60) tick();
    vectors++;
    if (state2 !== 4'd0 || retired2 !== 4'd15) begin
      miscompares++; $display("FAIL wrap_15: state %0d retired %0d want 0/15", state2, retired2);
    end
    repeat (4) tick();
    vectors++;
    if (state2 !== 4'd0 || retired2 !== 4'd0) begin
      miscompares++; $display("FAIL wrap_0: state %0d retired %0d want 0/0", state2, retired2);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq_jal();
    test_illegal();
    test_reset_abort();
    test_rtype();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control state machine of the multicycle RV32I datapath.
- Drives every datapath select and enable, including the 2-bit ResultSrc select of the 3:1 result mux (00=ALUOut, 01=Data, 10=ALUResult, 11=unused/zero).
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Also keeps a retired-instruction counter for the performance bench.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  opcode field from the instruction register; stable from DECODE onward.
- pc_update  out  1  PC write enable (unconditional).
- branch  out  1  branch qualifier; PC is written if branch & zero.
- reg_write  out  1  register file write enable.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction register load enable.
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- result_src  out  2  result mux select, encoding as above.
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=A register.
- alu_src_b  out  2  ALU B select: 00=WriteData, 01=ImmExt, 10=constant 4.
- alu_op  out  2  ALU decode: 00=add, 01=sub, 10=funct decode.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset, asynchronous on rst high:
  - state=FETCH (0); retired=0.
  - Outputs take the FETCH values immediately.
- Outputs are Moore (function of state only), combinational. All outputs not listed for a state are 0.
- Opcodes decoded: lw=0000011, sw=0100011, R-type=0110011, I-ALU=0010011, beq=1100011, jal=1101111.
- States, encoding, outputs and next state:
  - FETCH(0): ir_write=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1. Next: DECODE.
  - DECODE(1): alu_src_a=01, alu_src_b=01, alu_op=00. Next: lw/sw->MEMADR; R->EXECUTER; I-ALU->EXECUTEI; jal->JAL; beq->BEQ; any other opcode->FETCH (illegal opcode, no retire).
  - MEMADR(2): alu_src_a=10, alu_src_b=01, alu_op=00. Next: lw->MEMREAD, sw->MEMWRITE.
  - MEMREAD(3): result_src=00, adr_src=1. Next: MEMWB.
  - MEMWB(4): result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE(5): result_src=00, adr_src=1, mem_write=1. Next: FETCH.
  - EXECUTER(6): alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB(7): result_src=00, reg_write=1. Next: FETCH.
  - EXECUTEI(8): alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
  - JAL(9): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB.
  - BEQ(10): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- Encodings 11–15 are unreachable. If entered, next state is FETCH and all outputs are 0.
- Cycle counts, FETCH to FETCH inclusive: lw=5, sw=4, R=4, I=4, jal=4, beq=3.
- retired increments by 1 on the clock edge that moves from MEMWB, MEMWRITE, ALUWB or BEQ to FETCH.
  - It does not increment on DECODE->FETCH (illegal opcode).
  - It wraps modulo 2^CNT_W with no saturation.
- rst asserted mid-instruction aborts the instruction: state returns to FETCH and retired clears, both asynchronously.
- op is sampled only in DECODE and MEMADR. Changes to op in other states have no effect.

Test Plan:
- Reset held with op=0110011 -> state=0, ir_write=1, pc_update=1, alu_src_b=10, result_src=10, retired=0. After release, states run 0,1,6,7,0; reg_write=1 only in state 7 with result_src=00; retired=1.
- lw (op=0000011) -> states 0,1,2,3,4,0. In state 3: adr_src=1. In state 4: result_src=01, reg_write=1. retired +1.
- sw (op=0100011) -> states 0,1,2,5,0. mem_write=1 for exactly one cycle, in state 5. reg_write never asserted. retired +1.
- beq (op=1100011) then jal (op=1101111):
  - beq -> states 0,1,10,0, with branch=1 and alu_op=01 in state 10.
  - jal -> states 0,1,9,7,0, with pc_update=1 in 9.
  - retired +2 total.
- Illegal op=1111111 -> states 0,1,0; retired unchanged. rst pulsed during state 3 of a lw -> state=0 and retired=0 without waiting for a clock edge.
- Force retired to 2^CNT_W−1 (CNT_W=4 build, retired=15), then complete an R-type -> retired=0.
